reset_seq_ctrl: RTL and testbench



---
 rtl/reset_seq_ctrl_if.sv | 27 ++
 rtl/reset_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_ctrl_if.sv
// Reset sequencer bundle: reboot request in, staged resets and status out.
interface reset_seq_ctrl_if;
   logic       soft_reboot_req;
   logic       p_reset_n;
   logic       clk_enb;
   logic       s_reset_n;
   logic       seq_busy;
   logic [3:0] soft_boot_cnt;

   modport master (
      input  soft_reboot_req,
      output p_reset_n,
      output clk_enb,
      output s_reset_n,
      output seq_busy,
      output soft_boot_cnt
   );

   modport slave (
      output soft_reboot_req,
      input  p_reset_n,
      input  clk_enb,
      input  s_reset_n,
      input  seq_busy,
      input  soft_boot_cnt
   );
endinterface

// File: rtl/reset_seq_ctrl.sv
// Staged power-on / soft-reboot reset sequencer for strap and pinmux logic.
// Releases p_reset_n, clk_enb, s_reset_n in order; soft reboot keeps p_reset_n.
module reset_seq_ctrl #(
   parameter int CNT_W = 8,
   parameter int P_DLY = 16,
   parameter int C_DLY = 8,
   parameter int S_DLY = 8,
   parameter int H_DLY = 16
) (
   input  logic             clk,
   input  logic             e_reset_n,
   reset_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      WAIT_P,
      WAIT_C,
      WAIT_S,
      ACTIVE,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] P_END = CNT_W'(P_DLY - 1);
   localparam logic [CNT_W-1:0] C_END = CNT_W'(C_DLY - 1);
   localparam logic [CNT_W-1:0] S_END = CNT_W'(S_DLY - 1);
   localparam logic [CNT_W-1:0] H_END = CNT_W'(H_DLY - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic       p_q;
   logic       p_nxt;
   logic       c_q;
   logic       c_nxt;
   logic       s_q;
   logic       s_nxt;
   logic       busy_q;
   logic       busy_nxt;
   logic [3:0] boot_q;
   logic [3:0] boot_nxt;

   logic sync1;
   logic sync2;
   logic sync2_d;
   logic req_rise;

   // Request may be asynchronous; sync2_d gives the edge reference.
   always_ff @(posedge clk or negedge e_reset_n) begin
      if (!e_reset_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
      end else begin
         sync1   <= bus.soft_reboot_req;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   assign req_rise = sync2 & ~sync2_d;

   always_ff @(posedge clk or negedge e_reset_n) begin
      if (!e_reset_n) begin
         state  <= WAIT_P;
         cnt    <= '0;
         p_q    <= 1'b0;
         c_q    <= 1'b0;
         s_q    <= 1'b0;
         busy_q <= 1'b1;
         boot_q <= 4'd0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         p_q    <= p_nxt;
         c_q    <= c_nxt;
         s_q    <= s_nxt;
         busy_q <= busy_nxt;
         boot_q <= boot_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      p_nxt     = p_q;
      c_nxt     = c_q;
      s_nxt     = s_q;
      boot_nxt  = boot_q;
      unique case (state)
         WAIT_P: begin
            if (cnt == P_END) begin
               p_nxt     = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT_C;
            end
         end
         WAIT_C: begin
            if (cnt == C_END) begin
               c_nxt     = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT_S;
            end
         end
         WAIT_S: begin
            if (cnt == S_END) begin
               s_nxt     = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            cnt_nxt = '0;
            if (req_rise) begin
               s_nxt     = 1'b0;
               c_nxt     = 1'b0;
               state_nxt = HOLD;
               if (boot_q != 4'hF) begin
                  boot_nxt = boot_q + 4'd1;
               end
            end
         end
         HOLD: begin
            // p_reset_n is left alone so sticky straps survive.
            if (cnt == H_END) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_C;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = WAIT_P;
         end
      endcase
      busy_nxt = (state_nxt != ACTIVE);
   end

   assign bus.p_reset_n     = p_q;
   assign bus.clk_enb       = c_q;
   assign bus.s_reset_n     = s_q;
   assign bus.seq_busy      = busy_q;
   assign bus.soft_boot_cnt = boot_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Randomised scoreboard bench for reset_seq_ctrl against an edge-time model.
module tb_reset_seq_ctrl;

   localparam int P = 16;
   localparam int C = 8;
   localparam int S = 8;
   localparam int H = 16;

   typedef struct packed {
      logic       p;
      logic       c;
      logic       s;
      logic       busy;
      logic [3:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic e_reset_n = 1'b0;

   reset_seq_ctrl_if bus ();

   reset_seq_ctrl #(
      .CNT_W (8),
      .P_DLY (P),
      .C_DLY (C),
      .S_DLY (S),
      .H_DLY (H)
   ) dut (
      .clk       (clk),
      .e_reset_n (e_reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   // Model: expected outputs from the edge numbers at which each
   // output is due to rise, counted from e_reset_n release.
   int e = 0;
   int c_at = P + C;
   int s_at = P + C + S;
   int bc = 0;
   bit h1 = 0, h2 = 0, h3 = 0;

   always @(posedge clk) begin
      exp_t x;
      if (!e_reset_n) begin
         e = 0;
         c_at = P + C;
         s_at = P + C + S;
         bc = 0;
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         e++;
         if (h2 && !h3 && (e - 1) >= s_at) begin
            c_at = e + H + C;
            s_at = c_at + S;
            if (bc < 15) bc++;
         end
         h3 = h2; h2 = h1; h1 = bus.soft_reboot_req;
      end
      x.p    = (e >= P);
      x.c    = (e >= c_at);
      x.s    = (e >= s_at);
      x.busy = !(e >= s_at);
      x.cnt  = 4'(bc);
      exp_q.push_back(x);
   end

   always @(negedge clk) begin
      exp_t x;
      exp_t a;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         a = {bus.p_reset_n, bus.clk_enb, bus.s_reset_n,
              bus.seq_busy, bus.soft_boot_cnt};
         checks++;
         if (a !== x) begin
            errors++;
            $display("FAIL outputs t=%0t edge=%0d got p=%b c=%b s=%b busy=%b cnt=%0d exp p=%b c=%b s=%b busy=%b cnt=%0d",
                     $time, e, a.p, a.c, a.s, a.busy, a.cnt,
                     x.p, x.c, x.s, x.busy, x.cnt);
         end
      end
   end

   task automatic go_edge(input int n);
      int guard = 0;
      while (e < n - 1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         errors++;
         $display("FAIL go_edge timeout got edge=%0d need %0d", e, n - 1);
      end
   endtask

   task automatic pulse_reset(input int hold);
      exp_t a;
      @(negedge clk);
      #1 e_reset_n = 1'b0;
      #1;
      a = {bus.p_reset_n, bus.clk_enb, bus.s_reset_n,
           bus.seq_busy, bus.soft_boot_cnt};
      checks++;
      if (a !== 8'b0001_0000) begin
         errors++;
         $display("FAIL async_reset got %b exp %b", a, 8'b0001_0000);
      end
      repeat (hold) @(negedge clk);
      #1 e_reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.soft_reboot_req = 1'b0;
      idle(3);
      #1 e_reset_n = 1'b1;

      // Power-on then a soft reboot sampled at edge 100, dropped at 110.
      go_edge(100);
      bus.soft_reboot_req = 1'b1;
      go_edge(110);
      bus.soft_reboot_req = 1'b0;

      // Held request across the whole reboot, then re-raised.
      go_edge(150);
      bus.soft_reboot_req = 1'b1;
      go_edge(240);
      bus.soft_reboot_req = 1'b0;
      go_edge(250);
      bus.soft_reboot_req = 1'b1;
      go_edge(260);
      bus.soft_reboot_req = 1'b0;
      go_edge(300);

      // Reset at edge 20 of power-on, then again during HOLD.
      pulse_reset(3);
      go_edge(20);
      pulse_reset(2);
      go_edge(40);
      bus.soft_reboot_req = 1'b1;
      go_edge(44);
      bus.soft_reboot_req = 1'b0;
      go_edge(50);
      pulse_reset(4);

      // Request pulse during WAIT_C must be ignored.
      go_edge(18);
      bus.soft_reboot_req = 1'b1;
      go_edge(20);
      bus.soft_reboot_req = 1'b0;
      go_edge(60);

      // Saturation: 17 reboots with random pulse width and spacing.
      for (int i = 0; i < 17; i++) begin
         bus.soft_reboot_req = 1'b1;
         idle($urandom_range(1, 8));
         bus.soft_reboot_req = 1'b0;
         idle($urandom_range(40, 60));
      end
      checks++;
      if (bus.soft_boot_cnt !== 4'd15) begin
         errors++;
         $display("FAIL saturation got %0d exp 15", bus.soft_boot_cnt);
      end

      // Random request toggling with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0)
            bus.soft_reboot_req = ~bus.soft_reboot_req;
         if ($urandom_range(0, 399) == 0)
            pulse_reset($urandom_range(1, 4));
      end

      bus.soft_reboot_req = 1'b0;
      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
